// File: rtl/bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// bist_ctrl_if
// Harness-side bus of the BIST sequencer.
//   start, abort, golden_sig       : harness -> sequencer (run control)
//   busy, done, pass               : sequencer -> harness (run status)
//   signature[7:0], pat_cnt[15:0]  : sequencer -> harness (MISR value, progress)
// modport master : the test harness
// modport slave  : the bist_ctrl sequencer
// -----------------------------------------------------------------------------
interface bist_ctrl_if;
    logic        start;
    logic        abort;
    logic [7:0]  golden_sig;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  signature;
    logic [15:0] pat_cnt;

    modport master (
        output start, abort, golden_sig,
        input  busy, done, pass, signature, pat_cnt
    );

    modport slave (
        input  start, abort, golden_sig,
        output busy, done, pass, signature, pat_cnt
    );
endinterface

// File: rtl/bist_ctrl.sv
// -----------------------------------------------------------------------------
// bist_ctrl
// Built-in self-test sequencer for a two-input, one-output combinational CUT.
// An 8-bit LFSR supplies patterns, each held SETTLE_CYCLES cycles before the
// CUT response is folded into an 8-bit MISR. After NUM_PATTERNS captures the
// signature is compared against golden_sig.
// Ports:
//   iccad_clk    : clock, rising edge
//   iccad_rst_n  : asynchronous active-low reset
//   bus          : harness bus (start/abort/golden_sig in; busy/done/pass/
//                  signature/pat_cnt out)
//   cut_inp1/2   : CUT inputs, lfsr[0] / lfsr[1]
//   cut_out      : CUT primary output
// -----------------------------------------------------------------------------
module bist_ctrl #(
    parameter int         NUM_PATTERNS  = 64,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] SEED          = 8'h01
) (
    input  logic         iccad_clk,
    input  logic         iccad_rst_n,
    bist_ctrl_if.slave   bus,
    output logic         cut_inp1,
    output logic         cut_inp2,
    input  logic         cut_out
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0]  SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0] LAST_PAT    = 16'(NUM_PATTERNS - 1);
    localparam logic [7:0]  LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

    if (NUM_PATTERNS < 1 || NUM_PATTERNS > 65535) begin : g_bad_num_patterns
        $error("bist_ctrl: NUM_PATTERNS must be in 1..65535");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("bist_ctrl: SETTLE_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [7:0]  misr_q, misr_d;
    logic [7:0]  settle_q, settle_d;
    logic [15:0] pat_cnt_q, pat_cnt_d;
    logic        pass_q, pass_d;
    logic        busy_q, done_q;
    logic [7:0]  lfsr_next, misr_next;

    always_comb begin
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        misr_next = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3] ^ cut_out};

        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        settle_d  = settle_q;
        pat_cnt_d = pat_cnt_q;
        pass_d    = pass_q;

        unique case (state_q)
            IDLE, DONE: begin
                // start wins over abort here; abort only cancels a live run
                if (bus.start) begin
                    state_d   = APPLY;
                    lfsr_d    = SEED_EFF;
                    misr_d    = 8'h00;
                    pat_cnt_d = 16'd0;
                    settle_d  = 8'd0;
                    pass_d    = 1'b0;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q + 8'd1;
                    if (settle_q == LAST_SETTLE) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                // abort beats the final capture, so done never rises on it
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    misr_d    = misr_next;
                    lfsr_d    = lfsr_next;
                    pat_cnt_d = pat_cnt_q + 16'd1;
                    settle_d  = 8'd0;
                    if (pat_cnt_q == LAST_PAT) begin
                        state_d = DONE;
                        pass_d  = (misr_next == bus.golden_sig);
                    end else begin
                        state_d = APPLY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // busy/done are registered from the next state so every output is a flop
    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            misr_q    <= 8'h00;
            settle_q  <= 8'd0;
            pat_cnt_q <= 16'd0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            settle_q  <= settle_d;
            pat_cnt_q <= pat_cnt_d;
            pass_q    <= pass_d;
            busy_q    <= (state_d == APPLY) || (state_d == CAPTURE);
            done_q    <= (state_d == DONE);
        end
    end

    assign cut_inp1      = lfsr_q[0];
    assign cut_inp2      = lfsr_q[1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = misr_q;
    assign bus.pat_cnt   = pat_cnt_q;

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

Built-in self-test sequencer for a small combinational cell netlist (two primary inputs, one primary output, as produced by the netlist enhancer flow). It generates pseudo-random input patterns with an 8-bit LFSR, holds each pattern for a programmable settle time, and compacts the netlist response into an 8-bit MISR signature. At the end of a run it compares the signature against a golden value and reports pass/fail. It sits between the test harness and the circuit under test (CUT), clocked on the same domain as the CUT's registers.

## Interface
- NUM_PATTERNS, 64: patterns applied per run; legal range 1..65535.
- SETTLE_CYCLES, 2: cycles each pattern is held before capture; legal range 1..255.
- SEED, 8'h01: LFSR start value; 8'h00 is illegal and is replaced by 8'h01.
- iccad_clk  in  1  sole clock, rising edge.
- iccad_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run.
- abort  in  1  synchronous cancel of a run in progress.
- golden_sig  in  8  expected signature, sampled in the DONE-entry cycle.
- cut_inp1  out  1  CUT input 1 = lfsr[0].
- cut_inp2  out  1  CUT input 2 = lfsr[1].
- cut_out  in  1  CUT primary output.
- busy  out  1  high in APPLY/CAPTURE.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  valid when done; 1 iff signature == golden_sig.
- signature  out  8  current MISR value.
- pat_cnt  out  16  patterns captured so far in the current run.

## Operation
- States: IDLE, APPLY, CAPTURE, DONE.
- IDLE: start=1 -> APPLY; lfsr<=SEED, misr<=0, pat_cnt<=0, settle counter<=0, pass<=0.
- APPLY: CUT inputs are driven from lfsr; the settle counter increments each cycle; after SETTLE_CYCLES cycles -> CAPTURE.
- CAPTURE (1 cycle): misr<={misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]^cut_out}; lfsr<={lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; pat_cnt+=1. If pat_cnt (before increment) == NUM_PATTERNS-1 -> DONE, otherwise -> APPLY with the settle counter cleared.
- DONE: pass<=(misr==golden_sig) on entry, computed with the post-capture misr. Outputs hold. start=1 -> restarts exactly as from IDLE; done and pass clear on that edge.
- abort=1 in APPLY/CAPTURE -> IDLE next edge. The captured MISR/pat_cnt values are kept for debug, and done stays 0. abort has priority over the CAPTURE-to-DONE transition. abort is ignored in IDLE/DONE.
- start is ignored while busy. If start and abort are both high in IDLE or DONE, start wins.
- CUT inputs are held at lfsr[1:0] in every state. In IDLE/DONE, lfsr is frozen.
- pat_cnt never wraps: NUM_PATTERNS ≤ 65535 by parameter check. The LFSR period is 255 and its wrap is legal.

## Timing
- Reset (async assert, sync release): state=IDLE, lfsr=SEED, misr=8'h00, pat_cnt=0, busy=0, done=0, pass=0, so cut_inp1/cut_inp2 = SEED[0]/SEED[1].
- busy rises 1 cycle after start is sampled.
- Each pattern takes SETTLE_CYCLES+1 cycles. cut_out is sampled at the end of the CAPTURE cycle, i.e. SETTLE_CYCLES+1 cycles after the pattern is first driven.
- done rises NUM_PATTERNS*(SETTLE_CYCLES+1)+1 cycles after the start edge; busy falls on the same edge.
- Reset asserted mid-run returns all outputs to reset values immediately, with no wait for a clock.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then SEED=8'h01: cut_inp1=1, cut_inp2=0, busy=done=pass=0, signature=8'h00.
- NUM_PATTERNS=6, SETTLE_CYCLES=1, cut_out tied 0, golden_sig=8'h00, start pulse: CUT input pairs (inp2,inp1) over successive patterns = 01,10,00,00,01,11 (lfsr 01,02,04,08,11,23). done rises 13 cycles after start with pass=1, signature=8'h00, pat_cnt=6.
- NUM_PATTERNS=2, cut_out tied 1, golden_sig=8'h03: signature after pattern 1 = 8'h01, after pattern 2 = 8'h03. pass=1. Repeat with golden_sig=8'h07 -> pass=0.
- abort asserted during the second APPLY of a 64-pattern run: busy drops next cycle, done=0, pat_cnt=1. A following start restarts with pat_cnt=0 and lfsr=SEED.
- start pulses while busy are ignored (run length unchanged). start in DONE clears done and pass and begins a new run. Same-cycle start+abort in IDLE starts a run.
- iccad_rst_n pulsed low mid-CAPTURE: outputs return to reset values asynchronously. No run resumes until a new start.
